lemming_dig_arbiter: RTL

//  Shares one digging tool among N lemming walker FSMs; at most one lemming digs at a time.

---
 rtl/lemming_dig_arbiter_if.sv | 26 ++
 rtl/lemming_dig_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/lemming_dig_arbiter_if.sv
// Signal bundle between level control, the lemming walker FSMs and the dig arbiter.
interface lemming_dig_arbiter_if #(
    parameter int N = 4
) ();
    // Handshake: a lemming holds req high (level). The arbiter answers the winner with a
    // single-cycle dig pulse. From then on the owner reports progress on digging_in/aaah_in.
    // grant stays high on the owner until supervision ends the dig.
    logic [N-1:0] req;
    logic [N-1:0] walking;
    logic [N-1:0] digging_in;
    logic [N-1:0] aaah_in;
    logic [N-1:0] dig;
    logic [N-1:0] grant;
    logic         busy;
    logic         timeout_err;

    modport master (
        output req, walking, digging_in, aaah_in,
        input  dig, grant, busy, timeout_err
    );

    modport slave (
        input  req, walking, digging_in, aaah_in,
        output dig, grant, busy, timeout_err
    );
endinterface

// File: rtl/lemming_dig_arbiter.sv
// Round-robin owner of the single digging tool: issues a dig pulse, then supervises the
// owner's digging/falling status with a wait window, a dig timeout and a cooldown.
module lemming_dig_arbiter #(
    parameter int N        = 4,
    parameter int MAX_DIG  = 31,
    parameter int COOLDOWN = 2
) (
    input  logic                 clk,
    input  logic                 areset,
    lemming_dig_arbiter_if.slave bus,
    output logic [2:0]           dbg_state
);
    localparam int IW = $clog2(N);
    localparam int DW = $clog2(MAX_DIG + 1);
    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAITDIG = 3'd2,
        S_ACTIVE  = 3'd3,
        S_COOL    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    dig_q, dig_d, grant_q, grant_d;
    logic            busy_q, busy_d, terr_q, terr_d;
    logic [IW-1:0]   rr_q, rr_d, gidx_q, gidx_d;
    logic            wait_q, wait_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [CW-1:0]   ccnt_q, ccnt_d;

    logic [N-1:0]    elig;
    logic            any_elig;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   scan_idx;
    logic            own_digging, own_aaah;

    assign elig        = bus.req & bus.walking;
    assign own_digging = bus.digging_in[gidx_q];
    assign own_aaah    = bus.aaah_in[gidx_q];

    // Scan from the farthest offset down so the nearest eligible after rr_q wins.
    always_comb begin
        any_elig = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int off = N; off >= 1; off--) begin
            scan_idx = IW'((int'(rr_q) + off) % N);
            if (elig[scan_idx]) begin
                any_elig = 1'b1;
                win_idx  = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            dig_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            rr_q    <= IW'(N - 1);
            gidx_q  <= '0;
            wait_q  <= 1'b0;
            dcnt_q  <= '0;
            ccnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
            wait_q  <= wait_d;
            dcnt_q  <= dcnt_d;
            ccnt_q  <= ccnt_d;
        end
    end

    // The wait window is two WAITDIG cycles: wait_q marks the second one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (any_elig) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAITDIG;
            S_WAITDIG: begin
                if (own_digging)            state_d = S_ACTIVE;
                else if (own_aaah || wait_q) state_d = S_COOL;
            end
            S_ACTIVE:  if (!own_digging || dcnt_q == DW'(MAX_DIG)) state_d = S_COOL;
            S_COOL:    if (ccnt_q == CW'(COOLDOWN - 1)) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dig_d   = '0;
        grant_d = grant_q;
        terr_d  = 1'b0;
        rr_d    = rr_q;
        gidx_d  = gidx_q;
        wait_d  = wait_q;
        dcnt_d  = dcnt_q;
        ccnt_d  = ccnt_q;
        busy_d  = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (any_elig) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    dig_d            = '0;
                    dig_d[win_idx]   = 1'b1;
                    gidx_d           = win_idx;
                end
            end
            S_ISSUE:   wait_d = 1'b0;
            S_WAITDIG: begin
                if (own_digging) dcnt_d = DW'(1);
                else             wait_d = 1'b1;
            end
            S_ACTIVE: begin
                if (own_digging) begin
                    if (dcnt_q == DW'(MAX_DIG)) terr_d = 1'b1;
                    else                        dcnt_d = dcnt_q + DW'(1);
                end
            end
            S_COOL: begin
                grant_d = '0;
                rr_d    = gidx_q;
                ccnt_d  = ccnt_q + CW'(1);
            end
            default: ;
        endcase
        if (state_d == S_COOL && state_q != S_COOL) ccnt_d = '0;
    end

    assign bus.dig         = dig_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
    assign dbg_state       = state_q;
endmodule
